// File: rtl/fsm_vector_sequencer.sv
// Replays stored {dut_rst, dut_in} stimulus words into an fsm under test, one per clock,
// capturing each response into a buffer and folding it into a MISR signature.
module fsm_vector_sequencer #(
  parameter int unsigned      IN_LEN   = 7,
  parameter int unsigned      OUT_LEN  = 7,
  parameter int unsigned      DEPTH    = 141,
  parameter int unsigned      AW       = 8,
  parameter int unsigned      SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(16'h1021),
  parameter logic             IDLE_RST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [IN_LEN:0]    cfg_wdata,
  input  logic [AW:0]        len,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [AW:0]        vec_cnt,
  output logic               dut_rst,
  output logic [IN_LEN-1:0]  dut_in,
  input  logic [OUT_LEN-1:0] dut_out,
  input  logic [AW-1:0]      resp_raddr,
  output logic [OUT_LEN-1:0] resp_rdata,
  output logic [SIG_W-1:0]   signature
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic [IN_LEN:0]    stim_mem [DEPTH];
  logic [OUT_LEN-1:0] resp_mem [DEPTH];

  state_e             state_q, state_d;
  logic [AW:0]        len_q, len_d;
  logic [AW:0]        idx_q, idx_d;
  logic [AW:0]        vec_cnt_q, vec_cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic               pin_rst_q, pin_rst_d;
  logic [IN_LEN-1:0]  pin_in_q, pin_in_d;
  logic [OUT_LEN-1:0] resp_rdata_q;

  logic [AW:0]        len_lim;
  logic [AW:0]        idx_nxt;
  logic [SIG_W-1:0]   misr_nxt;
  logic               cap_en;
  logic               cfg_addr_ok;
  logic               raddr_ok;

  assign len_lim     = (len > DepthW) ? DepthW : len;
  assign idx_nxt     = idx_q + 1'b1;
  assign cfg_addr_ok = {1'b0, cfg_addr} < DepthW;
  assign raddr_ok    = {1'b0, resp_raddr} < DepthW;

  // MISR: shift left, fold in the polynomial when the MSB falls out, xor the new response.
  assign misr_nxt = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(dut_out);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    vec_cnt_d = vec_cnt_q;
    sig_d     = sig_q;
    pin_rst_d = IDLE_RST;
    pin_in_d  = '0;
    cap_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          len_d     = len_lim;
          idx_d     = '0;
          vec_cnt_d = '0;
          sig_d     = '0;
          if (len_lim == '0) begin
            state_d = StDone;
          end else begin
            state_d               = StRun;
            {pin_rst_d, pin_in_d} = stim_mem[0];
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          cap_en    = 1'b1;
          vec_cnt_d = idx_nxt;
          sig_d     = misr_nxt;
          idx_d     = idx_nxt;
          if (idx_nxt < len_q) begin
            {pin_rst_d, pin_in_d} = stim_mem[idx_nxt[AW-1:0]];
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= '0;
      vec_cnt_q    <= '0;
      sig_q        <= '0;
      pin_rst_q    <= IDLE_RST;
      pin_in_q     <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      vec_cnt_q    <= vec_cnt_d;
      sig_q        <= sig_d;
      pin_rst_q    <= pin_rst_d;
      pin_in_q     <= pin_in_d;
      resp_rdata_q <= raddr_ok ? resp_mem[resp_raddr] : '0;
    end
  end

  // Buffers are not reset; writes are suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (rst && cfg_we && (state_q != StRun) && cfg_addr_ok) begin
      stim_mem[cfg_addr] <= cfg_wdata;
    end
    if (rst && cap_en) begin
      resp_mem[idx_q[AW-1:0]] <= dut_out;
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign vec_cnt    = vec_cnt_q;
  assign dut_rst    = pin_rst_q;
  assign dut_in     = pin_in_q;
  assign resp_rdata = resp_rdata_q;
  assign signature  = sig_q;

endmodule

// File: tb/tb_fsm_vector_sequencer.sv
// Randomized bench for fsm_vector_sequencer against a behavioural model of the replay,
// response buffer and MISR, with a combinational stub standing in for the fsm.
module tb_fsm_vector_sequencer;

  localparam int IN_LEN  = 7;
  localparam int OUT_LEN = 7;
  localparam int DEPTH   = 141;
  localparam int AW      = 8;
  localparam int SIG_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [IN_LEN:0]    cfg_wdata;
  logic [AW:0]        len;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [AW:0]        vec_cnt;
  logic               dut_rst;
  logic [IN_LEN-1:0]  dut_in;
  logic [OUT_LEN-1:0] dut_out;
  logic [AW-1:0]      resp_raddr;
  logic [OUT_LEN-1:0] resp_rdata;
  logic [SIG_W-1:0]   signature;

  fsm_vector_sequencer u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .len        (len),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .vec_cnt    (vec_cnt),
    .dut_rst    (dut_rst),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .resp_raddr (resp_raddr),
    .resp_rdata (resp_rdata),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  // Stub fsm: echoes its input, or a fixed pattern while held in reset.
  assign dut_out = dut_rst ? 7'h55 : dut_in;

  logic [7:0] m_stim [DEPTH];
  logic [6:0] m_resp [DEPTH];
  bit         m_resp_ok [DEPTH];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] d);
    int v;
    v = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) v = v ^ 'h1021;
    v = v ^ int'(d);
    return v[15:0];
  endfunction

  function automatic logic [6:0] stub_of(input logic [7:0] w);
    return w[7] ? 7'h55 : w[6:0];
  endfunction

  task automatic cfg_write(input int addr, input logic [7:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = addr[AW-1:0];
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < DEPTH) m_stim[addr] = data;
  endtask

  // One replay; abort_k / rst_k name the vector index at which to interrupt (-1 = never).
  task automatic run(input int len_v, input int abort_k, input int rst_k, input bit wr_busy,
                     output logic [15:0] sig_out);
    int          lim;
    logic [15:0] s;
    bit          stopped;
    lim     = (len_v > DEPTH) ? DEPTH : len_v;
    s       = '0;
    stopped = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len   = len_v[AW:0];
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < lim; k++) begin
      chk("run_busy", busy, 1);
      chk("run_done_low", done, 0);
      chk("run_pins", {dut_rst, dut_in}, m_stim[k]);
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pins", {dut_rst, dut_in}, 8'h80);
        chk("abort_cnt", vec_cnt, k);
        chk("abort_sig", signature, s);
        stopped = 1'b1;
        break;
      end
      if (k == rst_k) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pins", {dut_rst, dut_in}, 8'h80);
        chk("rst_cnt", vec_cnt, 0);
        chk("rst_sig", signature, 0);
        chk("rst_rdata", resp_rdata, 0);
        s       = '0;
        stopped = 1'b1;
        break;
      end
      if (wr_busy && k == 0) begin
        cfg_we    = 1'b1;
        cfg_addr  = '0;
        cfg_wdata = ~m_stim[0];
      end
      @(negedge clk);
      cfg_we       = 1'b0;
      m_resp[k]    = stub_of(m_stim[k]);
      m_resp_ok[k] = 1'b1;
      s            = misr_step(s, stub_of(m_stim[k]));
    end
    if (!stopped) begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_pins", {dut_rst, dut_in}, 8'h80);
      chk("end_cnt", vec_cnt, lim);
      chk("end_sig", signature, s);
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
    sig_out = s;
  endtask

  task automatic readback(input int addr);
    @(negedge clk);
    resp_raddr = addr[AW-1:0];
    @(negedge clk);
    if (addr >= DEPTH) chk("resp_oob", resp_rdata, 0);
    else if (m_resp_ok[addr]) chk("resp_rd", resp_rdata, m_resp[addr]);
  endtask

  initial begin
    logic [15:0] s1;
    logic [15:0] s2;
    rst        = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    len        = '0;
    start      = 1'b0;
    abort      = 1'b0;
    resp_raddr = '0;
    for (int i = 0; i < DEPTH; i++) m_resp_ok[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", vec_cnt, 0);
    chk("reset_sig", signature, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_pins", {dut_rst, dut_in}, 8'h80);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) cfg_write(i, 8'($urandom));

    cfg_write(0, 8'h01);
    cfg_write(1, 8'h02);
    cfg_write(2, 8'hFF);
    run(3, -1, -1, 1'b0, s1);

    cfg_write(0, 8'h05);
    cfg_write(1, 8'h03);
    run(2, -1, -1, 1'b0, s1);
    chk("t2_sig", signature, 16'h0009);
    readback(0);
    readback(1);
    chk("t2_rd1", resp_rdata, 7'h03);

    cfg_write(0, 8'h01);
    for (int i = 1; i <= 16; i++) cfg_write(i, 8'h00);
    run(17, -1, -1, 1'b0, s1);
    chk("t3_sig", signature, 16'h1021);

    run(0, -1, -1, 1'b0, s1);
    run(200, -1, -1, 1'b0, s1);
    readback(140);
    readback(200);

    run(5, 2, -1, 1'b0, s1);
    run(5, -1, 2, 1'b0, s1);

    run(10, -1, -1, 1'b1, s1);
    cfg_write(200, 8'hAA);
    run(10, -1, -1, 1'b0, s2);
    chk("rerun_sig", signature, s1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done", done, 0);

    repeat (25) begin
      int nw;
      int lv;
      int ak;
      nw = $urandom_range(0, 4);
      for (int i = 0; i < nw; i++) cfg_write($urandom_range(0, 255), 8'($urandom));
      lv = ($urandom_range(0, 9) == 0) ? $urandom_range(141, 300) : $urandom_range(0, 60);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      run(lv, ak, -1, 1'b0, s1);
      readback($urandom_range(0, 150));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
